decode_stage: RTL
=================

# decode_stage

Registered, parametrised instruction-decode stage for the puzzle-solver core. It sits between fetch and execute and turns each fetched opcode word into a control bundle for execute. It adds a valid/ready handshake, a one-cycle pipeline register, branch redirect generation, and an optional register and zero-flag scoreboard that stalls on data hazards.

## Interface
Parameters:
- OP_W, 16: instruction word width. Opcode is the top 4 bits, op[OP_W-1:OP_W-4].
- PC_W, 8: program-counter width.
- RADDR_W, 5: register address width. The register file has 2**RADDR_W entries.
- DATA_W, 17: width of the immediate/data field.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset. One clock; reset is synchronous and active-high.
- in_valid, in, 1: fetch presents `in_op`.
- in_ready, out, 1: decode accepts `in_op` this cycle.
- in_op, in, OP_W: instruction word.
- flush, in, 1: discard the held bundle.
- zf, in, 1: zero flag from execute.
- out_valid, out, 1: bundle valid.
- out_ready, in, 1: execute takes the bundle.
- out_alu_op, out, 4: ALU operation.
- out_dst, out, RADDR_W: destination register.
- out_src1, out, RADDR_W: source operand 1.
- out_src0, out, RADDR_W: source operand 0.
- out_reg_we, out, 1: register write enable.
- out_sel1, out, 1: operand select 1.
- out_sel2, out, 1: operand select 2.
- out_mem_we, out, 1: memory write enable.
- out_data, out, DATA_W: immediate/data value.
- redir_valid, out, 1: one-cycle branch-redirect pulse.
- redir_pc, out, PC_W: branch target.
- wb_valid, in, 1: writeback retires a register write to `wb_dst`.
- wb_dst, in, RADDR_W: register being retired.
- wb_zf_valid, in, 1: execute has updated `zf`.

## Operation
- Field positions, with R = RADDR_W:
  - Register format (INC, INC_3, COPY, COPY_3, REFERENCE, TO_*): dst = op[OP_W-5 -: R], src1 = next R bits, data = zero-extended remaining low bits.
  - Compare format (COMP, STORE): src1 = op[2R-1:R], src0 = op[R-1:0].
  - LI: dst = op[OP_W-5 -: R], data = zero-extended low OP_W-4-R bits.
  - Branch (JMP, JNZ): target = op[PC_W-1:0].
- Control values per opcode:
  - Register-writing opcodes set reg_we=1. This is every opcode except JMP, JNZ, COMP, CHECK, CHECK_3 and STORE.
  - STORE sets mem_we=1. All other opcodes have mem_we=0.
  - sel1=1 for COPY, COPY_3, COMP, REFERENCE, STORE, LI.
  - sel2=1 for TO_UP, TO_DOWN, TO_RIGHT, TO_LEFT.
  - CHECK: data = {op[1:0], zeros}, left-aligned to DATA_W.
  - Any field not listed for an opcode is driven to 0. No output is ever left unassigned.
- Flag producers: COMP, CHECK, CHECK_3.
- Branches:
  - JMP: redir_valid=1 at acceptance.
  - JNZ: redir_valid = zf at acceptance.
  - Branches also pass through as a bundle with reg_we=0 and mem_we=0.
- Hazard stall:
  - Triggered when any source used by the incoming opcode, or its dst if reg_we, is busy.
  - Triggered when the incoming opcode is JNZ and the flag is busy.
  - "Busy" means the bit is set in the scoreboard, or the item is written by the bundle currently held in the output register.
  - A stall forces in_ready=0.
- Scoreboard bits:
  - Register bit is set on issue (out_valid && out_ready && reg_we) and cleared on wb_valid for wb_dst.
  - Flag bit is set on issue of a flag producer and cleared on wb_zf_valid.
  - Set and clear of the same bit in one cycle: set wins.
- flush clears out_valid next cycle. It does not alter the scoreboard, because only issued bundles set bits. If in_valid is high in the same cycle as flush, that instruction is not accepted.

## Timing
- in_ready = (!out_valid || out_ready) && !hazard && !flush. It is combinational.
- Latency: a word accepted in cycle N appears on out_* with out_valid=1 in cycle N+1.
- Back-to-back issue at one instruction per cycle when there are no hazards.
- While out_valid=1 and out_ready=0, every out_* signal holds stable.
- redir_valid is registered. It is high exactly in cycle N+1 for a branch accepted in cycle N, and never for more than one cycle per branch.
- A dependent instruction stalls until the cycle after the wb_valid / wb_zf_valid that clears its bit. The clear is visible to the hazard check one cycle after the wb pulse.
- Reset: out_valid=0, redir_valid=0, all out_* bundle fields and redir_pc = 0, scoreboard all clear. Reset mid-stall drops the held bundle.

## Configuration
- DECODE_SCOREBOARD_EN defined: scoreboard and hazard stall are active as described above.
- DECODE_SCOREBOARD_EN undefined:
  - No scoreboard storage is built and the hazard term is 0.
  - wb_* inputs are ignored.
  - Software must insert NOPs to avoid hazards.

## Structure
- Package `decode_pkg` holds:
  - the 4-bit opcode localparams, JMP=0 through LI=15 in the order JMP, JNZ, INC, INC_3, COPY, COPY_3, COMP, CHECK, CHECK_3, REFERENCE, TO_UP, TO_DOWN, TO_RIGHT, TO_LEFT, STORE, LI;
  - the control-bundle struct typedef;
  - function predicates `writes_reg`, `writes_flag`, `uses_src0`, `uses_src1`.
- One sub-module `decode_scoreboard` contains the register and flag busy bits, the set/clear logic and the busy lookup. It is instantiated only under DECODE_SCOREBOARD_EN.

## Test plan
- INC dst=3 src1=3 accepted with out_ready=1 -> next cycle out_valid=1, dst=3, src1=3, reg_we=1, alu_op=2.
- JMP target 0x42 -> redir_valid pulses 1 cycle later, redir_pc=0x42. JNZ with zf=0 -> no redir_valid.
- INC r3 issued, then COPY reading r3 -> in_ready=0 until the cycle after wb_valid with wb_dst=3; then accepted.
- COMP issued, then JNZ -> stalled until wb_zf_valid. JNZ with zf=1 then redirects.
- Hold out_ready=0 for 5 cycles with a bundle present -> outputs stable, in_ready=0. Assert flush -> out_valid=0 next cycle, scoreboard unchanged.
- rst asserted with a bundle held and scoreboard bits set -> all outputs 0 and the next independent instruction is accepted immediately. Repeat the hazard scenario with DECODE_SCOREBOARD_EN undefined -> no stall.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcode map, control-bundle type and opcode predicates shared
// by the decode stage and its scoreboard.
package decode_pkg;

    localparam logic [3:0] OP_JMP       = 4'd0;
    localparam logic [3:0] OP_JNZ       = 4'd1;
    localparam logic [3:0] OP_INC       = 4'd2;
    localparam logic [3:0] OP_INC_3     = 4'd3;
    localparam logic [3:0] OP_COPY      = 4'd4;
    localparam logic [3:0] OP_COPY_3    = 4'd5;
    localparam logic [3:0] OP_COMP      = 4'd6;
    localparam logic [3:0] OP_CHECK     = 4'd7;
    localparam logic [3:0] OP_CHECK_3   = 4'd8;
    localparam logic [3:0] OP_REFERENCE = 4'd9;
    localparam logic [3:0] OP_TO_UP     = 4'd10;
    localparam logic [3:0] OP_TO_DOWN   = 4'd11;
    localparam logic [3:0] OP_TO_RIGHT  = 4'd12;
    localparam logic [3:0] OP_TO_LEFT   = 4'd13;
    localparam logic [3:0] OP_STORE     = 4'd14;
    localparam logic [3:0] OP_LI        = 4'd15;

    // Width-independent part of the bundle handed to execute.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_we;
        logic       sel1;
        logic       sel2;
        logic       mem_we;
    } ctrl_t;

    function automatic logic writes_reg(input logic [3:0] opc);
        case (opc)
            OP_JMP, OP_JNZ, OP_COMP, OP_CHECK, OP_CHECK_3, OP_STORE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic writes_flag(input logic [3:0] opc);
        case (opc)
            OP_COMP, OP_CHECK, OP_CHECK_3: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_src0(input logic [3:0] opc);
        case (opc)
            OP_COMP, OP_STORE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Register-format and compare-format opcodes both carry src1.
    function automatic logic uses_src1(input logic [3:0] opc);
        case (opc)
            OP_JMP, OP_JNZ, OP_CHECK, OP_CHECK_3, OP_LI: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [3:0] opc);
        ctrl_t c;
        c.alu_op = opc;
        c.reg_we = writes_reg(opc);
        c.mem_we = (opc == OP_STORE);
        c.sel1   = (opc == OP_COPY) || (opc == OP_COPY_3) || (opc == OP_COMP) ||
                   (opc == OP_REFERENCE) || (opc == OP_STORE) || (opc == OP_LI);
        c.sel2   = (opc == OP_TO_UP) || (opc == OP_TO_DOWN) ||
                   (opc == OP_TO_RIGHT) || (opc == OP_TO_LEFT);
        return c;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: busy bits for every register plus the zero flag.
// Bits are set when a bundle issues to execute and cleared by writeback;
// a set and clear landing on the same bit in one cycle leaves it set.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int RADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    set_reg_en,
    input  logic [RADDR_W-1:0]      set_reg_addr,
    input  logic                    set_flag_en,
    input  logic                    clr_reg_en,
    input  logic [RADDR_W-1:0]      clr_reg_addr,
    input  logic                    clr_flag_en,
    input  logic [2:0][RADDR_W-1:0] chk_addr,
    output logic [2:0]              chk_busy,
    output logic                    flag_busy
);

    localparam int NREG = 2 ** RADDR_W;

    logic [NREG-1:0] reg_busy_d, reg_busy_q;
    logic            flag_busy_d, flag_busy_q;

    // Next busy state: apply clear first so a simultaneous set wins.
    always_comb begin
        reg_busy_d  = reg_busy_q;
        flag_busy_d = flag_busy_q;
        if (clr_reg_en)  reg_busy_d[clr_reg_addr] = 1'b0;
        if (set_reg_en)  reg_busy_d[set_reg_addr] = 1'b1;
        if (clr_flag_en) flag_busy_d = 1'b0;
        if (set_flag_en) flag_busy_d = 1'b1;
    end

    // Busy-bit storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_busy_q  <= '0;
            flag_busy_q <= 1'b0;
        end else begin
            reg_busy_q  <= reg_busy_d;
            flag_busy_q <= flag_busy_d;
        end
    end

    // Lookup of the three operand addresses of the incoming instruction.
    always_comb begin
        for (int i = 0; i < 3; i++) chk_busy[i] = reg_busy_q[chk_addr[i]];
    end

    assign flag_busy = flag_busy_q;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode between fetch and execute.
// Produces the control bundle, a one-cycle branch redirect pulse and, when
// DECODE_SCOREBOARD_EN is defined, stalls on register / zero-flag hazards.
module decode_stage
    import decode_pkg::*;
#(
    parameter int OP_W    = 16,
    parameter int PC_W    = 8,
    parameter int RADDR_W = 5,
    parameter int DATA_W  = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic               flush,
    input  logic               zf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_alu_op,
    output logic [RADDR_W-1:0] out_dst,
    output logic [RADDR_W-1:0] out_src1,
    output logic [RADDR_W-1:0] out_src0,
    output logic               out_reg_we,
    output logic               out_sel1,
    output logic               out_sel2,
    output logic               out_mem_we,
    output logic [DATA_W-1:0]  out_data,
    output logic               redir_valid,
    output logic [PC_W-1:0]    redir_pc,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_dst,
    input  logic               wb_zf_valid
);

    // Low-bit data widths of register format and LI format.
    localparam int RF_DW = OP_W - 4 - 2 * RADDR_W;
    localparam int LI_DW = OP_W - 4 - RADDR_W;

    logic [3:0]         opc;
    ctrl_t              dec_ctrl;
    logic [RADDR_W-1:0] dec_dst, dec_src1, dec_src0;
    logic [DATA_W-1:0]  dec_data;
    logic               is_branch;
    logic               hazard, accept, issue;

    logic               out_valid_d, out_valid_q;
    ctrl_t              out_ctrl_d, out_ctrl_q;
    logic [RADDR_W-1:0] out_dst_d, out_dst_q;
    logic [RADDR_W-1:0] out_src1_d, out_src1_q;
    logic [RADDR_W-1:0] out_src0_d, out_src0_q;
    logic [DATA_W-1:0]  out_data_d, out_data_q;
    logic               redir_valid_d, redir_valid_q;
    logic [PC_W-1:0]    redir_pc_d, redir_pc_q;

    assign opc       = in_op[OP_W-1 -: 4];
    assign is_branch = (opc == OP_JMP) || (opc == OP_JNZ);

    // Field extraction; anything an opcode does not define stays zero.
    always_comb begin
        dec_ctrl = decode_ctrl(opc);
        dec_dst  = '0;
        dec_src1 = '0;
        dec_src0 = '0;
        dec_data = '0;
        case (opc)
            OP_INC, OP_INC_3, OP_COPY, OP_COPY_3, OP_REFERENCE,
            OP_TO_UP, OP_TO_DOWN, OP_TO_RIGHT, OP_TO_LEFT: begin
                dec_dst  = in_op[OP_W-5 -: RADDR_W];
                dec_src1 = in_op[OP_W-5-RADDR_W -: RADDR_W];
                dec_data = DATA_W'(in_op[RF_DW-1:0]);
            end
            OP_COMP, OP_STORE: begin
                dec_src1 = in_op[2*RADDR_W-1:RADDR_W];
                dec_src0 = in_op[RADDR_W-1:0];
            end
            OP_CHECK: dec_data = {in_op[1:0], {(DATA_W-2){1'b0}}};
            OP_LI: begin
                dec_dst  = in_op[OP_W-5 -: RADDR_W];
                dec_data = DATA_W'(in_op[LI_DW-1:0]);
            end
            default: ;
        endcase
    end

`ifdef DECODE_SCOREBOARD_EN
    logic [2:0][RADDR_W-1:0] chk_addr;
    logic [2:0]              sb_busy;
    logic [2:0]              held_hit;
    logic                    sb_flag_busy, held_flag;
    logic                    set_reg_en, set_flag_en;

    assign chk_addr    = {dec_dst, dec_src1, dec_src0};
    assign set_reg_en  = issue && out_ctrl_q.reg_we;
    assign set_flag_en = issue && writes_flag(out_ctrl_q.alu_op);

    decode_scoreboard #(.RADDR_W(RADDR_W)) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_reg_en   (set_reg_en),
        .set_reg_addr (out_dst_q),
        .set_flag_en  (set_flag_en),
        .clr_reg_en   (wb_valid),
        .clr_reg_addr (wb_dst),
        .clr_flag_en  (wb_zf_valid),
        .chk_addr     (chk_addr),
        .chk_busy     (sb_busy),
        .flag_busy    (sb_flag_busy)
    );

    // Busy = scoreboard bit or written by the bundle still sitting in the
    // output register (it has not issued, so the scoreboard cannot know).
    always_comb begin
        held_flag = out_valid_q && writes_flag(out_ctrl_q.alu_op);
        for (int i = 0; i < 3; i++)
            held_hit[i] = out_valid_q && out_ctrl_q.reg_we && (out_dst_q == chk_addr[i]);
        hazard = (uses_src0(opc)  && (sb_busy[0] || held_hit[0])) ||
                 (uses_src1(opc)  && (sb_busy[1] || held_hit[1])) ||
                 (writes_reg(opc) && (sb_busy[2] || held_hit[2])) ||
                 ((opc == OP_JNZ) && (sb_flag_busy || held_flag));
    end
`else
    // Without the scoreboard software spaces dependent instructions.
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_dst, wb_zf_valid};
    assign hazard    = 1'b0;
`endif

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid_q && out_ready;

    // Output register next state: load on accept, drop on flush or handoff.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_ctrl_d    = out_ctrl_q;
        out_dst_d     = out_dst_q;
        out_src1_d    = out_src1_q;
        out_src0_d    = out_src0_q;
        out_data_d    = out_data_q;
        redir_valid_d = accept && ((opc == OP_JMP) || ((opc == OP_JNZ) && zf));
        redir_pc_d    = redir_pc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = dec_ctrl;
            out_dst_d   = dec_dst;
            out_src1_d  = dec_src1;
            out_src0_d  = dec_src0;
            out_data_d  = dec_data;
            if (is_branch) redir_pc_d = in_op[PC_W-1:0];
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pipeline register and redirect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_ctrl_q    <= '0;
            out_dst_q     <= '0;
            out_src1_q    <= '0;
            out_src0_q    <= '0;
            out_data_q    <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_ctrl_q    <= out_ctrl_d;
            out_dst_q     <= out_dst_d;
            out_src1_q    <= out_src1_d;
            out_src0_q    <= out_src0_d;
            out_data_q    <= out_data_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_alu_op  = out_ctrl_q.alu_op;
    assign out_reg_we  = out_ctrl_q.reg_we;
    assign out_sel1    = out_ctrl_q.sel1;
    assign out_sel2    = out_ctrl_q.sel2;
    assign out_mem_we  = out_ctrl_q.mem_we;
    assign out_dst     = out_dst_q;
    assign out_src1    = out_src1_q;
    assign out_src0    = out_src0_q;
    assign out_data    = out_data_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;

endmodule
